// File: rtl/fifo_push_arb_if.sv
// fifo_push_arb_if: requester valid/ready handshake plus FIFO push and snooped pop signals.
interface fifo_push_arb_if #(
  parameter int W = 32,
  parameter int R = 4
);
  logic [R-1:0]   req_valid;
  logic [R*W-1:0] req_data;
  logic [R-1:0]   req_ready;
  logic           fifo_push;
  logic [W-1:0]   fifo_push_data;
  logic           fifo_pop;
  modport master (output req_valid, req_data, fifo_pop, input req_ready, fifo_push, fifo_push_data);
  modport slave  (input req_valid, req_data, fifo_pop, output req_ready, fifo_push, fifo_push_data);
endinterface

// File: rtl/fifo_push_arb.sv
// fifo_push_arb: round-robin push arbiter with FIFO credit tracking.
// Optional per-requester saturating grant counters under FIFO_PUSH_ARB_GRANT_CNT_EN.
module fifo_push_arb #(
  parameter int W = 32,
  parameter int N = 16,
  parameter int R = 4,
  localparam int CW = $clog2(N + 1),
  localparam int PW = (R > 1) ? $clog2(R) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_push_arb_if.slave        bus,
`ifdef FIFO_PUSH_ARB_GRANT_CNT_EN
  input  logic                  grant_cnt_clr,
  output logic [R*16-1:0]       grant_cnt_r,
`endif
  output logic [CW-1:0]         occupancy_r,
  output logic                  empty_r,
  output logic                  full_r,
  output logic                  err_underflow_r
);
  logic [CW-1:0] occ_q, occ_d;
  logic          empty_q, empty_d, full_q, full_d, err_q, err_d;
  logic [PW-1:0] last_q, last_d, win;
  logic          win_found, can_push, push, eff_pop;
  logic [R-1:0]  ready;
  int            idx;
  always_comb begin
    win = '0;
    win_found = 1'b0;
    idx = 0;
    for (int k = 1; k <= R; k++) begin
      idx = (int'(last_q) + k) % R;
      if (!win_found && bus.req_valid[idx]) begin
        win_found = 1'b1;
        win = PW'(idx);
      end
    end
    // Credit comes only from the registered count; a same-cycle pop never bypasses.
    can_push = !rst && (occ_q < CW'(N));
    ready = '0;
    ready[win] = win_found && can_push;
    push = |(bus.req_valid & ready);
    eff_pop = bus.fifo_pop && (occ_q != '0);
    occ_d = occ_q + CW'(push) - CW'(eff_pop);
    empty_d = (occ_d == '0);
    full_d = (occ_d == CW'(N));
    err_d = err_q | (bus.fifo_pop && (occ_q == '0));
    last_d = push ? win : last_q;
  end
  assign bus.req_ready      = ready;
  assign bus.fifo_push      = push;
  assign bus.fifo_push_data = push ? bus.req_data[int'(win)*W +: W] : '0;
  assign occupancy_r        = occ_q;
  assign empty_r            = empty_q;
  assign full_r             = full_q;
  assign err_underflow_r    = err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= PW'(R - 1);
    end else begin
      occ_q   <= occ_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end
`ifdef FIFO_PUSH_ARB_GRANT_CNT_EN
  logic [R*16-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < R; i++)
      cnt_d[i*16 +: 16] = grant_cnt_clr ? 16'h0 :
                          (ready[i] && cnt_q[i*16 +: 16] != 16'hFFFF) ? cnt_q[i*16 +: 16] + 16'h1 :
                          cnt_q[i*16 +: 16];
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign grant_cnt_r = cnt_q;
`endif
endmodule

// File: doc/fifo_push_arb.md
Name: fifo_push_arb

Overview:
- Round-robin push arbiter and credit manager in front of a single-clock FIFO of depth N.
- Up to R requesters each offer a word on a valid/ready handshake. One winner per cycle is pushed into the FIFO.
- The block tracks FIFO occupancy from its own pushes and the observed pops, so it never pushes into a full FIFO.
- Sits between the producer clients and the FIFO push interface; the FIFO pop interface is owned by the consumer and only snooped here.

Parameters:
- W, 32, data word width.
- N, 16, downstream FIFO depth in entries (>=2).
- R, 4, number of requesters (>=2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  R  per-requester offer valid.
- req_data  in  R*W  per-requester data; requester i occupies bits [i*W +: W].
- req_ready  out  R  one-hot (or zero) grant; a transfer happens when req_valid[i] & req_ready[i].
- fifo_push  out  1  push strobe to the FIFO.
- fifo_push_data  out  W  data of the granted requester.
- fifo_pop  in  1  snooped consumer pop strobe to the FIFO.
- occupancy_r  out  $clog2(N+1)  registered entry count.
- empty_r  out  1  occupancy_r == 0.
- full_r  out  1  occupancy_r == N.
- err_underflow_r  out  1  sticky: fifo_pop was seen while occupancy_r == 0.

Behaviour:
- Clock/reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - occupancy_r = 0, empty_r = 1, full_r = 0, err_underflow_r = 0.
  - Round-robin pointer last_r = R-1, so requester 0 has first priority.
- Credit:
  - can_push = (occupancy_r < N), computed from the registered count only.
  - A pop in the same cycle does not free a slot until the next cycle. There is no bypass.
- Arbitration (combinational, same cycle):
  - Search order is last_r+1, last_r+2, ... wrapping modulo R.
  - The first requester with req_valid set wins, if can_push.
  - req_ready is asserted only for the winner.
  - fifo_push = |(req_valid & req_ready).
  - fifo_push_data = winner's data. When fifo_push = 0 it is 0.
- req_ready never depends on req_ready. It may depend on req_valid, which is a combinational path valid->ready. Requesters must not make valid depend on ready.
- Pointer update: on a push, last_r <= winner index. Otherwise last_r holds.
- Fairness: with all R requesters continuously valid and credit available, grants rotate 0,1,...,R-1,0,... and each requester gets exactly 1 of every R grants.
- Occupancy update each cycle:
  - eff_pop = fifo_pop & (occupancy_r != 0).
  - occupancy_r <= occupancy_r + fifo_push - eff_pop.
  - Push and pop in the same cycle leave the count unchanged.
  - empty_r and full_r are registered from the next-state count, so they are consistent with occupancy_r in every cycle.
- Underflow: fifo_pop with occupancy_r == 0 is ignored for counting and sets err_underflow_r. It clears only on rst.
- Full: at occupancy_r == N, all req_ready bits are 0 and fifo_push = 0, regardless of valid or pop in that cycle.
- Latency: grant and push in the same cycle as valid. The count reflects the push on the next edge.
- Reset mid-operation: all state returns to reset values on the next edge. req_ready is held 0 during the rst cycle.
- Requester data is not buffered here; the arbiter adds no storage beyond the counters.

Optional Feature:
- Macro: FIFO_PUSH_ARB_GRANT_CNT_EN.
- When defined:
  - Adds output grant_cnt_r (R*16 bits); requester i occupies bits [i*16 +: 16].
  - Adds input grant_cnt_clr (1 bit).
  - Each 16-bit counter increments on its requester's grant and saturates at 16'hFFFF.
  - All counters reset to 0 on rst or when grant_cnt_clr = 1.
  - A clear and a grant in the same cycle give 0.
- When undefined: these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then req_valid=4'b1111 held for 8 cycles with fifo_pop=0 -> grants 0,1,2,3,0,1,2,3; occupancy_r=8; empty_r=0.
- From empty, req_valid=4'b0100 held for 16 cycles -> 16 grants to requester 2; full_r=1 after 16th edge; 17th cycle req_ready=0, fifo_push=0.
- At occupancy_r=16, assert fifo_pop with req_valid=4'b0001 -> no push that cycle, occupancy_r=15 next; push on the following cycle, occupancy_r back to 16.
- At occupancy_r=5, push and fifo_pop in the same cycle -> occupancy_r stays 5; last_r updates to the winner.
- From reset, fifo_pop=1 for one cycle -> occupancy_r stays 0; err_underflow_r=1 and sticky until rst.
- With FIFO_PUSH_ARB_GRANT_CNT_EN defined: 70000 grants to requester 1 -> grant_cnt_r[1] = 16'hFFFF; one cycle of grant_cnt_clr -> all counters 0.
